// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_pkg
//  Description : Shared types and the single-bit full-adder equation used by
//                the ripple-carry cell.
//  Revision    : 1.0  initial release
// ============================================================================
package full_adder_pkg;

    // Largest operand width the ripple chain is intended to be built at.
    localparam int C_MAX_WIDTH = 64;

    // Result of one full-adder cell.
    typedef struct packed {
        logic cout;
        logic s;
    } fa_result_t;

    // Classic full-adder equations: the carry propagates only when exactly
    // one operand bit is set, and is generated when both are.
    function automatic fa_result_t fa_cell(input logic a, input logic b, input logic cin);
        fa_result_t r;
        logic       p;
        p      = a ^ b;
        r.s    = p ^ cin;
        r.cout = (a & b) | (cin & p);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_if
//  Description : Operand / result bundle of the registered full adder.
//                master drives operands, slave (the adder) drives results.
//  Revision    : 1.0  initial release
// ============================================================================
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             past_carry;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output in_valid,
        output left,
        output right,
        output past_carry,
        input  sum,
        input  carry,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  left,
        input  right,
        input  past_carry,
        output sum,
        output carry,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : Purely combinational 1-bit full-adder cell (a, b, cin ->
//                s, cout). Building block of the ripple chain.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_bit
    import full_adder_pkg::*;
(
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);

    fa_result_t w_res;

    // One cell of the chain; no state, no lookahead.
    always_comb begin
        w_res = fa_cell(a, b, cin);
        s     = w_res.s;
        cout  = w_res.cout;
    end

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Registered WIDTH-bit ripple-carry adder.
//                {carry, sum} = left + right + past_carry, one cycle latency,
//                full throughput, results held while in_valid is low.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    full_adder_if.slave   bus
);

    // Carry chain: w_chain[0] is the incoming carry, w_chain[WIDTH] the
    // carry-out of the most significant cell.
    logic [WIDTH:0]   w_chain;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_out_valid;

    assign w_chain[0] = bus.past_carry;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_cell (
                .a    (bus.left[gi]),
                .b    (bus.right[gi]),
                .cin  (w_chain[gi]),
                .s    (w_sum[gi]),
                .cout (w_chain[gi+1])
            );
        end
    endgenerate

    // Output registers: capture on valid, hold otherwise; reset wins over
    // a valid operand set at the same edge. Operands are only looked at
    // when in_valid is high, so unknowns on idle cycles never reach sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_chain[WIDTH];
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder
//  Description : Self-checking bench for full_adder at WIDTH=1 and WIDTH=8,
//                with a behavioural arithmetic model and literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // ---------------- behavioural model ----------------
    logic       m1_sum, m1_carry, m1_valid;
    logic [7:0] m8_sum;
    logic       m8_carry, m8_valid;

    always @(posedge clk) begin
        if (!rst_n) begin
            m1_sum <= 1'b0; m1_carry <= 1'b0; m1_valid <= 1'b0;
            m8_sum <= 8'h00; m8_carry <= 1'b0; m8_valid <= 1'b0;
        end else begin
            m1_valid <= bus1.in_valid;
            m8_valid <= bus8.in_valid;
            if (bus1.in_valid)
                {m1_carry, m1_sum} <= 2'(bus1.left) + 2'(bus1.right) + 2'(bus1.past_carry);
            if (bus8.in_valid)
                {m8_carry, m8_sum} <= 9'(bus8.left) + 9'(bus8.right) + 9'(bus8.past_carry);
        end
    end

    // ---------------- literal expectations ----------------
    int         lit1_req = 0, lit1_ack = 0, lit8_req = 0, lit8_ack = 0;
    string      lit1_name, lit8_name;
    logic       lit1_s, lit1_c, lit1_v;
    logic [7:0] lit8_s;
    logic       lit8_c, lit8_v;

    task automatic lit1(input string nm, input logic s, input logic c, input logic v);
        lit1_name = nm; lit1_s = s; lit1_c = c; lit1_v = v;
        lit1_req++;
    endtask

    task automatic lit8(input string nm, input logic [7:0] s, input logic c, input logic v);
        lit8_name = nm; lit8_s = s; lit8_c = c; lit8_v = v;
        lit8_req++;
    endtask

    // ---------------- compare process ----------------
    int   n_vec  = 0;
    int   n_miss = 0;
    logic check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            n_vec++;
            if (bus1.sum !== m1_sum || bus1.carry !== m1_carry || bus1.out_valid !== m1_valid) begin
                n_miss++;
                $display("FAIL model1 t=%0t: got sum=%b carry=%b valid=%b, expected sum=%b carry=%b valid=%b",
                         $time, bus1.sum, bus1.carry, bus1.out_valid, m1_sum, m1_carry, m1_valid);
            end
            n_vec++;
            if (bus8.sum !== m8_sum || bus8.carry !== m8_carry || bus8.out_valid !== m8_valid) begin
                n_miss++;
                $display("FAIL model8 t=%0t: got sum=%h carry=%b valid=%b, expected sum=%h carry=%b valid=%b",
                         $time, bus8.sum, bus8.carry, bus8.out_valid, m8_sum, m8_carry, m8_valid);
            end
            if (lit1_req != lit1_ack) begin
                lit1_ack = lit1_req;
                n_vec++;
                if (bus1.sum !== lit1_s || bus1.carry !== lit1_c || bus1.out_valid !== lit1_v) begin
                    n_miss++;
                    $display("FAIL %s: got sum=%b carry=%b valid=%b, expected sum=%b carry=%b valid=%b",
                             lit1_name, bus1.sum, bus1.carry, bus1.out_valid, lit1_s, lit1_c, lit1_v);
                end
            end
            if (lit8_req != lit8_ack) begin
                lit8_ack = lit8_req;
                n_vec++;
                if (bus8.sum !== lit8_s || bus8.carry !== lit8_c || bus8.out_valid !== lit8_v) begin
                    n_miss++;
                    $display("FAIL %s: got sum=%h carry=%b valid=%b, expected sum=%h carry=%b valid=%b",
                             lit8_name, bus8.sum, bus8.carry, bus8.out_valid, lit8_s, lit8_c, lit8_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs just after a rising edge, then advance to
    // just after the next rising edge, where the result of these inputs is
    // visible and the following negedge checks it.
    task automatic cyc(input logic rn,
                       input logic v1, input logic l1, input logic r1, input logic c1,
                       input logic v8, input logic [7:0] l8, input logic [7:0] r8, input logic c8);
        rst_n           = rn;
        bus1.in_valid   = v1; bus1.left = l1; bus1.right = r1; bus1.past_carry = c1;
        bus8.in_valid   = v8; bus8.left = l8; bus8.right = r8; bus8.past_carry = c8;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_exp [8];
    logic [2:0] tt_idx;

    initial begin
        // (carry,sum) for vectors in order (l,r,c) = 000,010,100,110,001,011,101,111
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset held with a valid vector present
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        check_en = 1'b1;
        lit1("rst_hold0", 1'b0, 1'b0, 1'b0);
        lit8("rst8_hold0", 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        lit1("rst_hold1", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        lit1("rst_release", 1'b1, 1'b1, 1'b1);
        lit8("rst8_release", 8'h03, 1'b0, 1'b1);

        // Exhaustive 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            tt_idx = 3'(i);
            cyc(1'b1, 1'b1, tt_idx[1], tt_idx[0], tt_idx[2],
                1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            lit1($sformatf("truth_%0d%0d%0d", tt_idx[1], tt_idx[0], tt_idx[2]),
                 tt_exp[i][0], tt_exp[i][1], 1'b1);
        end

        // Hold after (1,1,1)
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            lit1($sformatf("hold_%0d", i), 1'b1, 1'b1, 1'b0);
        end

        // Ripple length and back-to-back at WIDTH=8
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        lit8("ripple_ff", 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        lit8("ripple_80", 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        lit8("b2b_first", 8'h46, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F, 1'b1);
        lit8("b2b_second", 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h07, 1'b0);
        lit8("pre_rst", 8'h0C, 1'b0, 1'b1);

        // Reset mid-stream discards a valid vector
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
        lit1("mid_rst1", 1'b0, 1'b0, 1'b0);
        lit8("mid_rst8", 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx);
        lit1("post_rst1", 1'b0, 1'b0, 1'b0);
        lit8("post_rst8", 8'h00, 1'b0, 1'b0);

        // Randomised traffic with idle X operands and occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic rn, v1, v8;
            rn = ($urandom_range(63) != 0);
            v1 = ($urandom_range(3) != 0);
            v8 = ($urandom_range(3) != 0);
            cyc(rn,
                v1, v1 ? 1'($urandom) : 1'bx, v1 ? 1'($urandom) : 1'bx, v1 ? 1'($urandom) : 1'bx,
                v8, v8 ? 8'($urandom) : 8'hxx, v8 ? 8'($urandom) : 8'hxx, v8 ? 1'($urandom) : 1'bx);
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
